// File: rtl/bk_sd_sequencer.sv
// rtl/bk_sd_sequencer.sv - backup-RAM save/load sector sequencer between hps_io and BRAM
module bk_sd_sequencer #(
  parameter int SECTORS = 128,
  parameter int TIMEOUT = 50000000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        bk_ena,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        autosave_en,
  input  logic        osd_open,
  input  logic        bk_change,
  input  logic        dl_done,
  input  logic        img_nonzero,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_loading,
  output logic        busy,
  output logic        sav_pending,
  output logic        error
);

  localparam int LW = $clog2(SECTORS);
  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lba_q, lba_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            loading_q, loading_d;
  logic            busy_q, busy_d;
  logic            pending_q, pending_d;
  logic            error_q, error_d;
  logic            is_load_q, is_load_d;
  logic            load_req_q, save_req_q, ack_q, auto_q;

  logic auto_trig;
  logic load_rise, save_rise, auto_rise, ack_rise, ack_fall;
  logic start_load, start_save, start;

  assign auto_trig = pending_q & osd_open & autosave_en;
  assign load_rise = load_req & ~load_req_q;
  assign save_rise = save_req & ~save_req_q;
  assign auto_rise = auto_trig & ~auto_q;
  assign ack_rise  = sd_ack & ~ack_q;
  assign ack_fall  = ~sd_ack & ack_q;

  // Load has priority; a save trigger that loses the same cycle is simply dropped.
  assign start_load = (state_q == ST_IDLE) & bk_ena & ((dl_done & img_nonzero) | load_rise);
  assign start_save = (state_q == ST_IDLE) & bk_ena & ~start_load & (save_rise | auto_rise);
  assign start      = start_load | start_save;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lba_q      <= '0;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      loading_q  <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= 1'b0;
      error_q    <= 1'b0;
      is_load_q  <= 1'b0;
      load_req_q <= 1'b0;
      save_req_q <= 1'b0;
      ack_q      <= 1'b0;
      auto_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lba_q      <= lba_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      loading_q  <= loading_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      error_q    <= error_d;
      is_load_q  <= is_load_d;
      load_req_q <= load_req;
      save_req_q <= save_req;
      ack_q      <= sd_ack;
      auto_q     <= auto_trig;
    end
  end

  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    loading_d = loading_q;
    busy_d    = busy_q;
    error_d   = error_q;
    is_load_d = is_load_q;

    // Starting a transfer snapshots BRAM, so it clears pending even if bk_change is seen now.
    if (start) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q | (bk_change & ~osd_open);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lba_d     = '0;
          busy_d    = 1'b1;
          loading_d = start_load;
          is_load_d = start_load;
          rd_d      = start_load;
          wr_d      = ~start_load;
          error_d   = 1'b0;
          cnt_d     = '0;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_XFER;
        end else if (cnt_q == CNT_LAST) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          error_d   = 1'b1;
          busy_d    = 1'b0;
          loading_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_XFER: begin
        if (ack_fall) begin
          if (&lba_q) begin
            busy_d    = 1'b0;
            loading_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            lba_d   = lba_q + LW'(1);
            rd_d    = is_load_q;
            wr_d    = ~is_load_q;
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sd_lba      = {{(32 - LW){1'b0}}, lba_q};
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign bk_loading  = loading_q;
  assign busy        = busy_q;
  assign sav_pending = pending_q;
  assign error       = error_q;

endmodule

// File: tb/tb_bk_sd_sequencer.sv
// tb/tb_bk_sd_sequencer.sv - self-checking bench for bk_sd_sequencer
module tb_bk_sd_sequencer;

  localparam int NSEC = 4;
  localparam int TMO  = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        bk_ena = 1'b0;
  logic        load_req = 1'b0;
  logic        save_req = 1'b0;
  logic        autosave_en = 1'b0;
  logic        osd_open = 1'b0;
  logic        bk_change = 1'b0;
  logic        dl_done = 1'b0;
  logic        img_nonzero = 1'b0;
  logic        sd_ack = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_loading, busy, sav_pending, error;

  int checks = 0;
  int errors = 0;
  logic exp_pend;

  bk_sd_sequencer #(.SECTORS(NSEC), .TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bk_ena(bk_ena),
    .load_req(load_req), .save_req(save_req), .autosave_en(autosave_en),
    .osd_open(osd_open), .bk_change(bk_change), .dl_done(dl_done),
    .img_nonzero(img_nonzero), .sd_ack(sd_ack), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_loading(bk_loading), .busy(busy),
    .sav_pending(sav_pending), .error(error)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Acknowledges n sectors of a transfer whose first request is already up.
  task automatic do_sectors(input bit is_load, input int dly, input int hold,
                            input int n, input int chg_sec);
    for (int s = 0; s < n; s++) begin
      chk("req_rd", {31'b0, sd_rd}, {31'b0, is_load});
      chk("req_wr", {31'b0, sd_wr}, {31'b0, ~is_load});
      chk("req_lba", sd_lba, 32'(s));
      chk("req_busy", {31'b0, busy}, 32'd1);
      chk("req_loading", {31'b0, bk_loading}, {31'b0, is_load});
      repeat (dly) step();
      chk("req_held", {31'b0, sd_rd | sd_wr}, 32'd1);
      if (s == chg_sec) bk_change = 1'b1;
      sd_ack = 1'b1;
      step();
      bk_change = 1'b0;
      chk("ack_clears_req", {30'b0, sd_rd, sd_wr}, 32'd0);
      repeat (hold - 1) step();
      chk("no_req_during_ack", {30'b0, sd_rd, sd_wr}, 32'd0);
      sd_ack = 1'b0;
      step();
      if (s == NSEC - 1) begin
        chk("done_busy", {31'b0, busy}, 32'd0);
        chk("done_loading", {31'b0, bk_loading}, 32'd0);
        chk("done_req", {30'b0, sd_rd, sd_wr}, 32'd0);
        chk("done_error", {31'b0, error}, 32'd0);
      end
    end
  endtask

  initial begin
    // reset state
    repeat (3) step();
    chk("rst_lba", sd_lba, 32'd0);
    chk("rst_flags", {26'b0, sd_rd, sd_wr, bk_loading, busy, sav_pending, error}, 32'd0);
    reset_n = 1'b1;
    bk_ena = 1'b1;
    step();

    // manual load, ack after 3 cycles, held 10
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    do_sectors(1'b1, 3, 10, NSEC, 99);

    // bk_change with OSD closed, then autosave on OSD open
    bk_change = 1'b1;
    step();
    bk_change = 1'b0;
    chk("pending_set", {31'b0, sav_pending}, 32'd1);
    autosave_en = 1'b1;
    osd_open = 1'b1;
    step();
    chk("auto_wr", {30'b0, sd_rd, sd_wr}, 32'd1);
    chk("auto_pending_clr", {31'b0, sav_pending}, 32'd0);
    do_sectors(1'b0, 2, 3, NSEC, 99);
    osd_open = 1'b0;
    autosave_en = 1'b0;
    step();

    // load and save together: load wins; save mid-transfer ignored
    load_req = 1'b1;
    save_req = 1'b1;
    step();
    load_req = 1'b0;
    save_req = 1'b0;
    step();
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    chk("both_rd_only", {30'b0, sd_rd, sd_wr}, 32'd2);
    do_sectors(1'b1, 1, 2, NSEC, 99);
    repeat (2) step();
    chk("dropped_save", {30'b0, busy, sd_wr}, 32'd0);

    // timeout: wr stays 16 cycles in REQ then drops with error
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    chk("tmo_wr_up", {31'b0, sd_wr}, 32'd1);
    repeat (TMO - 1) step();
    chk("tmo_wr_still", {31'b0, sd_wr}, 32'd1);
    step();
    chk("tmo_wr_drop", {31'b0, sd_wr}, 32'd0);
    chk("tmo_error", {31'b0, error}, 32'd1);
    chk("tmo_busy", {31'b0, busy}, 32'd0);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    chk("tmo_err_clr", {31'b0, error}, 32'd0);
    do_sectors(1'b1, 0, 1, NSEC, 99);

    // asynchronous reset during sector 2 of a load
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    do_sectors(1'b1, 1, 2, 2, 99);
    chk("pre_rst_lba", sd_lba, 32'd2);
    reset_n = 1'b0;
    #1;
    chk("async_rst_lba", sd_lba, 32'd0);
    chk("async_rst_flags", {29'b0, sd_rd, bk_loading, busy}, 32'd0);
    #1;
    reset_n = 1'b1;
    step();

    // bk_ena low blocks everything; dl_done needs a nonzero image
    bk_ena = 1'b0;
    load_req = 1'b1;
    dl_done = 1'b1;
    img_nonzero = 1'b1;
    step();
    load_req = 1'b0;
    dl_done = 1'b0;
    step();
    chk("ena_low_blocked", {29'b0, busy, sd_rd, sd_wr}, 32'd0);
    bk_ena = 1'b1;
    img_nonzero = 1'b0;
    dl_done = 1'b1;
    step();
    dl_done = 1'b0;
    step();
    chk("img_zero_blocked", {29'b0, busy, sd_rd, sd_wr}, 32'd0);

    // randomized transfers against the pending/transfer model
    exp_pend = 1'b0;
    for (int t = 0; t < 8; t++) begin
      int op, dly, hold, chg;
      bit osd, pre, drop_ena, is_load;
      op = $urandom_range(0, 2);
      dly = $urandom_range(0, 6);
      hold = $urandom_range(1, 5);
      chg = $urandom_range(0, NSEC);
      osd = 1'($urandom_range(0, 1));
      pre = 1'($urandom_range(0, 1));
      drop_ena = 1'($urandom_range(0, 1));
      is_load = (op != 2);
      osd_open = osd;
      if (pre) begin
        bk_change = 1'b1;
        step();
        bk_change = 1'b0;
        if (!osd) exp_pend = 1'b1;
        chk("rnd_pre_pending", {31'b0, sav_pending}, {31'b0, exp_pend});
      end
      case (op)
        0: load_req = 1'b1;
        1: begin dl_done = 1'b1; img_nonzero = 1'b1; end
        default: save_req = 1'b1;
      endcase
      step();
      load_req = 1'b0;
      save_req = 1'b0;
      dl_done = 1'b0;
      exp_pend = 1'b0;
      chk("rnd_start_pending", {31'b0, sav_pending}, 32'd0);
      if (drop_ena) bk_ena = 1'b0;
      do_sectors(is_load, dly, hold, NSEC, chg);
      bk_ena = 1'b1;
      if (chg < NSEC && !osd) exp_pend = 1'b1;
      chk("rnd_end_pending", {31'b0, sav_pending}, {31'b0, exp_pend});
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bk_sd_sequencer.md
Name: bk_sd_sequencer

Overview:
- Sequences backup-RAM (BRAM) save/load transfers between the system BRAM port and the hps_io SD sector interface.
- Issues one sd_rd/sd_wr request per 512-byte sector, walks sd_lba over SECTORS sectors, and tracks pending-save state.
- Triggers transfers from manual OSD load/save, autosave-on-OSD-open, and auto-load after ROM download.
- Adds a per-sector ack timeout. Sits in emu between hps_io and the system BRAM_* ports. Drives the bk_loading term of the core reset.

Parameters:
SECTORS, 128, sectors per transfer; power of two, 2..65536
TIMEOUT, 50000000, clk_sys cycles allowed between request assertion and sd_ack rise

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
bk_ena  in  1  save file mounted and writable; requests ignored when 0
load_req  in  1  OSD load level; rising edge triggers load
save_req  in  1  OSD save level; rising edge triggers save
autosave_en  in  1  autosave option
osd_open  in  1  OSD visible
bk_change  in  1  BRAM written by core (pulse or level)
dl_done  in  1  one-cycle pulse at ROM download end
img_nonzero  in  1  mounted save image size nonzero
sd_ack  in  1  hps_io sector ack
sd_lba  out  32  current sector LBA
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
bk_loading  out  1  load in progress (holds core in reset)
busy  out  1  any transfer in progress
sav_pending  out  1  unsaved BRAM changes exist
error  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0. State IDLE. Edge-detect registers 0. Timeout counter 0.
- Edge detection uses registered copies of load_req, save_req, sd_ack and auto_trig.
  - auto_trig = sav_pending & osd_open & autosave_en.
  - A save trigger is a save_req rise or an auto_trig rise.
- States: IDLE, REQ, XFER.
- IDLE, start conditions:
  - Start needs bk_ena=1.
  - dl_done & img_nonzero starts a load.
  - Else a load_req rise starts a load.
  - Else a save trigger starts a save.
  - A load wins over a save in the same cycle. A losing trigger is dropped, not queued.
- IDLE, on start (next cycle):
  - sd_lba=0 and busy=1.
  - bk_loading=1 for a load, 0 for a save.
  - sd_rd=load, sd_wr=~load.
  - error cleared, timeout counter cleared.
  - Go to REQ.
- REQ:
  - On an sd_ack rise, clear sd_rd/sd_wr the following cycle and go to XFER.
  - The counter increments each cycle. At TIMEOUT-1 with no ack: sd_rd=sd_wr=0, error=1, busy=0, bk_loading=0, go to IDLE.
- XFER:
  - Wait for an sd_ack fall. No timeout applies.
  - If sd_lba[log2(SECTORS)-1:0] is all ones: busy=0, bk_loading=0, go to IDLE.
  - Else: sd_lba+1, reassert the same request bit, clear the counter, go to REQ.
- sd_lba wraps only within the low log2(SECTORS) bits. Upper bits stay 0.
- sd_rd and sd_wr are never both 1. At most one request is outstanding.
- Triggers arriving while busy=1 are ignored.
- A bk_ena fall mid-transfer does not abort the transfer.
- sav_pending:
  - Set when bk_change & ~osd_open.
  - Cleared in the cycle a transfer starts. Clear wins over set in that cycle.
  - bk_change during a transfer with the OSD closed sets it again.
- A reset_n assertion mid-transfer returns everything to reset values immediately.
- Latency: request rises 1 cycle after the trigger edge. The next sector's request rises 1 cycle after the sd_ack fall.

Test Plan:
- SECTORS=4, bk_ena=1, pulse load_req. Ack each request 3 cycles after it asserts and hold ack 10 cycles. Required: sd_rd pulses with sd_lba 0,1,2,3, sd_wr=0 throughout, bk_loading=1 until the 4th ack fall, then busy=0 and error=0.
- bk_change with osd_open=0 sets sav_pending. With autosave_en=1, raise osd_open. Required: save starts next cycle, sd_wr=1 at lba 0, sav_pending=0. Completes 4 sectors.
- Raise load_req and save_req in the same cycle. Required: load only (sd_rd=1, sd_wr never 1). Pulse save_req mid-transfer: ignored.
- TIMEOUT=16, start save, never ack. Required: sd_wr drops after 16 cycles in REQ, error=1, busy=0. A later load_req clears error.
- Assert reset_n=0 during sector 2 of a load. Required: sd_rd, bk_loading, busy, sd_lba all 0 asynchronously.
- bk_ena=0, pulse load_req and dl_done. Required: no request. dl_done with img_nonzero=0 and bk_ena=1: no request.
